// File: rtl/ck2ck_fifo_push_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ck2ck_fifo_push_arb
//  Description : Round-robin arbiter that lets N_REQ requesters push bursts
//                of words into a single downstream FIFO.  A grant lasts
//                until the packet's last word, MAX_BURST words, or a gap in
//                the owner's valid.  A full FIFO parks the grant in STALL.
//  Options     : define CK2CK_PUSH_ARB_STATS_EN to add per-requester
//                16-bit wrapping counters of accepted words (pushCnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module ck2ck_fifo_push_arb #(
    parameter int DATA_W    = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       ckFast,
    input  logic                       srstFast,
    input  logic [N_REQ-1:0]           reqVld,
    input  logic [N_REQ*DATA_W-1:0]    reqData,
    input  logic [N_REQ-1:0]           reqLast,
    output logic [N_REQ-1:0]           reqRdy,
    input  logic                       fifoFull,
    output logic                       fifoPush,
    output logic [DATA_W-1:0]          fifoData,
    output logic [$clog2(N_REQ)-1:0]   grantId,
    output logic                       busy
`ifdef CK2CK_PUSH_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]        pushCnt
`endif
);

    localparam int c_ID_W = $clog2(N_REQ);
    localparam int c_BC_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_GRANT = 2'd1;
    localparam logic [1:0] c_STALL = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_ID_W-1:0] r_grant_id;
    logic [c_ID_W-1:0] r_rr_ptr;
    logic [c_BC_W-1:0] r_burst;

    logic [DATA_W-1:0] w_data [N_REQ];
    logic [c_ID_W:0]   w_idx;
    logic              w_pick_found;
    logic [c_ID_W-1:0] w_pick_id;
    logic              w_vld_g;
    logic              w_last_g;
    logic [DATA_W-1:0] w_data_g;
    logic              w_in_grant;
    logic              w_accept;
    logic [c_BC_W-1:0] w_burst_inc;
    logic              w_at_max;
    logic              w_release;
    logic [c_ID_W-1:0] w_ptr_inc;

    // Unpack the flat data bus into one word per requester
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_slice
            assign w_data[i] = reqData[i*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_vld_g  = reqVld[r_grant_id];
    assign w_last_g = reqLast[r_grant_id];
    assign w_data_g = w_data[r_grant_id];

    // Reset in flight suppresses any handshake in the same cycle
    assign w_in_grant  = (r_state == c_GRANT) && !srstFast;
    assign w_accept    = w_in_grant && !fifoFull && w_vld_g;
    assign w_burst_inc = r_burst + 1'b1;
    assign w_at_max    = (w_burst_inc == c_BC_W'(MAX_BURST));
    // Single release point: last word, burst limit, or a gap in the owner's valid
    assign w_release   = w_in_grant && !fifoFull && (!w_vld_g || w_last_g || w_at_max);
    assign w_ptr_inc   = (r_grant_id == c_ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_idx        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_ID_W+1)'(k);
            if (w_idx >= (c_ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (c_ID_W+1)'(N_REQ);
            end
            if (!w_pick_found && reqVld[w_idx[c_ID_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_id    = w_idx[c_ID_W-1:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge ckFast) begin
        if (srstFast) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = c_GRANT;
                end
            end
            c_GRANT: begin
                if (fifoFull) begin
                    w_state_nxt = c_STALL;
                end else if (w_release) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_STALL: begin
                if (!fifoFull) begin
                    w_state_nxt = c_GRANT;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Owner, round-robin pointer and burst counter
    always_ff @(posedge ckFast) begin
        if (srstFast) begin
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_burst    <= '0;
        end else begin
            if (r_state == c_IDLE && w_pick_found) begin
                r_grant_id <= w_pick_id;
                r_burst    <= '0;
            end else if (w_accept) begin
                r_burst <= w_burst_inc;
            end
            if (w_release) begin
                r_rr_ptr <= w_ptr_inc;
            end
        end
    end

    // FSM outputs: only the owner sees ready, and only while the FIFO has room
    always_comb begin
        reqRdy   = '0;
        fifoPush = 1'b0;
        fifoData = '0;
        busy     = (r_state != c_IDLE);
        grantId  = r_grant_id;
        if (w_in_grant) begin
            reqRdy[r_grant_id] = !fifoFull;
            fifoPush           = w_accept;
            fifoData           = w_data_g;
        end
    end

`ifdef CK2CK_PUSH_ARB_STATS_EN
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_stats
            logic [15:0] r_cnt;
            // Wrapping count of words accepted from requester i
            always_ff @(posedge ckFast) begin
                if (srstFast) begin
                    r_cnt <= '0;
                end else if (w_accept && r_grant_id == c_ID_W'(i)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign pushCnt[i*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_ck2ck_fifo_push_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ck2ck_fifo_push_arb
//  Description : Self-checking bench for ck2ck_fifo_push_arb.  Directed
//                scenarios load per-requester word sources; the expected
//                push order is queued up front and compared on each push.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ck2ck_fifo_push_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           ckFast = 1'b0;
    logic           srstFast;
    logic [N-1:0]   reqVld;
    logic [N*W-1:0] reqData;
    logic [N-1:0]   reqLast;
    logic [N-1:0]   reqRdy;
    logic           fifoFull;
    logic           fifoPush;
    logic [W-1:0]   fifoData;
    logic [1:0]     grantId;
    logic           busy;
`ifdef CK2CK_PUSH_ARB_STATS_EN
    logic [N*16-1:0] pushCnt;
`endif

    always #5 ckFast = ~ckFast;

    ck2ck_fifo_push_arb #(.DATA_W(W), .N_REQ(N), .MAX_BURST(4)) u_dut (
        .ckFast   (ckFast),
        .srstFast (srstFast),
        .reqVld   (reqVld),
        .reqData  (reqData),
        .reqLast  (reqLast),
        .reqRdy   (reqRdy),
        .fifoFull (fifoFull),
        .fifoPush (fifoPush),
        .fifoData (fifoData),
        .grantId  (grantId),
        .busy     (busy)
`ifdef CK2CK_PUSH_ARB_STATS_EN
        ,
        .pushCnt  (pushCnt)
`endif
    );

    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0] src_mem [N][32];
    logic       src_lst [N][32];
    int         src_n   [N];
    int         src_rd  [N];
    bit         en      [N];
    int         exp_q[$];
    int         pc[$];
    bit         busy_hist [4096];
    int         cyc    = 0;
    int         base   = 0;
    int         n_req1 = 0;
    bit         chk_stall = 0;
    bit         chk_rst   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (en[i] && src_rd[i] < src_n[i]) begin
                reqVld[i]         = 1'b1;
                reqData[i*W +: W] = src_mem[i][src_rd[i]];
                reqLast[i]        = src_lst[i][src_rd[i]];
            end else begin
                reqVld[i]         = 1'b0;
                reqData[i*W +: W] = '0;
                reqLast[i]        = 1'b0;
            end
        end
    endtask

    task automatic load(input int r, input int n, input bit last_end);
        for (int k = 0; k < n; k++) begin
            src_mem[r][k] = 8'(base + 16*r + k);
            src_lst[r][k] = last_end && (k == n - 1);
        end
        src_n[r]  = n;
        src_rd[r] = 0;
        en[r]     = 1'b0;
    endtask

    task automatic expect_w(input int r, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) exp_q.push_back((r << 8) | int'(src_mem[r][k]));
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0; src_n[i] = 0; src_rd[i] = 0;
        end
        pc.delete();
        base += 8'h40;
        drive();
    endtask

    // One clock: sample outputs mid-cycle, check pushes, then advance sources
    task automatic step();
        logic [N-1:0] acc;
        int e;
        #1;
        acc = reqVld & reqRdy;
        busy_hist[cyc] = busy;
        if (chk_stall) begin
            check_eq("stall_push", int'(fifoPush), 0);
            check_eq("stall_rdy",  int'(reqRdy), 0);
            check_eq("stall_busy", int'(busy), 1);
            check_eq("stall_gid",  int'(grantId), 2);
        end
        if (chk_rst) begin
            check_eq("rst_push", int'(fifoPush), 0);
            check_eq("rst_rdy",  int'(reqRdy), 0);
        end
        if (fifoPush) begin
            pc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check_eq("extra_push", int'(fifoPush), 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("push_data", int'(fifoData), e & 255);
                check_eq("push_id",   int'(grantId), e >> 8);
                if ((e >> 8) == 1) n_req1++;
            end
        end
        @(posedge ckFast);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (acc[i]) src_rd[i]++;
        drive();
    endtask

    task automatic run_drain(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            step();
            k++;
        end
        check_eq({tag, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_pushes(input string tag, input int n, input int budget);
        int k = 0;
        while (pc.size() < n && k < budget) begin
            step();
            k++;
        end
        check_eq({tag, "_pushes"}, pc.size(), n);
    endtask

    task automatic check_idle(input string tag);
        #1;
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_push"}, int'(fifoPush), 0);
        check_eq({tag, "_rdy"},  int'(reqRdy), 0);
        check_eq({tag, "_data"}, int'(fifoData), 0);
        check_eq({tag, "_gid"},  int'(grantId), 0);
    endtask

    initial begin
        int start;
        srstFast = 1'b1;
        fifoFull = 1'b0;
        reqVld = '0; reqData = '0; reqLast = '0;
        for (int i = 0; i < N; i++) begin en[i] = 0; src_n[i] = 0; src_rd[i] = 0; end
        step();
        step();
        srstFast = 1'b0;
        check_idle("reset");
`ifdef CK2CK_PUSH_ARB_STATS_EN
        check_eq("reset_pushcnt", int'(pushCnt != '0), 0);
`endif

        // Requesters 1 and 2, single-word packets: 1 then 2, 1-cycle latency
        clear_all();
        load(1, 1, 1); load(2, 1, 1);
        expect_w(1, 0, 0); expect_w(2, 0, 0);
        en[1] = 1; en[2] = 1; drive();
        start = cyc;
        run_drain("rr12", 20);
        check_eq("rr12_latency", pc[0] - start, 1);
        check_eq("rr12_last_gid", int'(grantId), 2);

        // Pointer now at 3: requesters 0 and 3 -> 3 first, then 0
        clear_all();
        load(0, 1, 1); load(3, 1, 1);
        expect_w(3, 0, 0); expect_w(0, 0, 0);
        en[0] = 1; en[3] = 1; drive();
        run_drain("rr30", 20);

        // Requester 0 alone, 8 words: burst of 4, one IDLE cycle, re-grant
        clear_all();
        load(0, 8, 1);
        expect_w(0, 0, 7);
        en[0] = 1; drive();
        run_drain("burst", 40);
        check_eq("burst_contig", pc[3] - pc[2], 1);
        check_eq("burst_regrant_gap", pc[4] - pc[3], 2);
        check_eq("burst_idle_busy", int'(busy_hist[pc[3] + 1]), 0);

        // Requester 2 stalled 3 cycles after 2 words; count survives the stall
        clear_all();
        load(2, 6, 1);
        expect_w(2, 0, 5);
        en[2] = 1; drive();
        run_pushes("stall_pre", 2, 20);
        fifoFull = 1'b1;
        chk_stall = 1'b1;
        repeat (3) step();
        chk_stall = 1'b0;
        fifoFull = 1'b0;
        run_drain("stall", 40);
        check_eq("stall_resume_gap", pc[2] - pc[1], 5);
        check_eq("stall_burst_end", pc[4] - pc[3], 2);

        // Requester 3 drops valid after 2 words: gap release, search from 0
        clear_all();
        load(3, 2, 0); load(0, 1, 1); load(1, 1, 1);
        expect_w(3, 0, 1); expect_w(0, 0, 0); expect_w(1, 0, 0);
        en[0] = 1; en[1] = 1; en[3] = 1; drive();
        run_drain("gap", 40);
        check_eq("gap_release_timing", pc[2] - pc[1], 3);
        check_eq("gap_busy_hold", int'(busy_hist[pc[1] + 1]), 1);
        check_eq("gap_busy_low", int'(busy_hist[pc[1] + 2]), 0);

        // Reset mid-burst on requester 1: no push in the reset cycle
        clear_all();
        load(1, 8, 0);
        expect_w(1, 0, 1);
        en[1] = 1; drive();
        run_pushes("rstmid_pre", 2, 20);
        srstFast = 1'b1;
        chk_rst  = 1'b1;
        step();
        chk_rst  = 1'b0;
        srstFast = 1'b0;
        check_eq("rstmid_sb_empty", exp_q.size(), 0);
        clear_all();
        n_req1 = 0;
        check_idle("rstmid");
`ifdef CK2CK_PUSH_ARB_STATS_EN
        check_eq("rstmid_pushcnt", int'(pushCnt != '0), 0);
`endif

        // Pointer back at 0 after reset: 1 wins over 2
        load(1, 1, 1); load(2, 1, 1);
        expect_w(1, 0, 0); expect_w(2, 0, 0);
        en[1] = 1; en[2] = 1; drive();
        run_drain("post_rst", 20);

        // reqLast on the 4th word: single release, pointer 0 -> 1
        clear_all();
        load(0, 4, 1);
        expect_w(0, 0, 3);
        en[0] = 1; drive();
        run_drain("coinc", 30);
        clear_all();
        load(0, 1, 1); load(1, 1, 1);
        expect_w(1, 0, 0); expect_w(0, 0, 0);
        en[0] = 1; en[1] = 1; drive();
        run_drain("coinc_next", 20);

`ifdef CK2CK_PUSH_ARB_STATS_EN
        #1;
        check_eq("pushcnt_req1", int'(pushCnt[16 +: 16]), n_req1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
